// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives one outstanding instruction-memory request.
// Fetched words go into the IF/ID register, with stall buffering and redirect flushing.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] buf_inst_reg;
    logic [31:0] buf_pc_reg;
    logic [31:0] pending_pc_reg;
    logic        req_reg;
    logic        id_valid_reg;
    logic [31:0] id_inst_reg;
    logic [31:0] id_pc_reg;
    logic [31:0] id_pc_plus4_reg;

    logic [31:0] redirect_tgt;
    logic [31:0] pc_plus4;
    logic [31:0] buf_pc_plus4;

    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign pc_plus4     = pc_reg + 32'd4;
    assign buf_pc_plus4 = buf_pc_reg + 32'd4;

    assign imem_req    = req_reg;
    assign imem_addr   = pc_reg;
    assign id_valid    = id_valid_reg;
    assign id_inst     = id_inst_reg;
    assign id_pc       = id_pc_reg;
    assign id_pc_plus4 = id_pc_plus4_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_PC;
            buf_inst_reg    <= 32'd0;
            buf_pc_reg      <= 32'd0;
            pending_pc_reg  <= 32'd0;
            req_reg         <= 1'b0;
            id_valid_reg    <= 1'b0;
            id_inst_reg     <= NOP_INST;
            id_pc_reg       <= 32'd0;
            id_pc_plus4_reg <= 32'd0;
        end else begin
            // A redirect always flushes IF/ID, regardless of stall.
            if (redirect) begin
                id_valid_reg    <= 1'b0;
                id_inst_reg     <= NOP_INST;
                id_pc_reg       <= 32'd0;
                id_pc_plus4_reg <= 32'd0;
            end
            case (state_reg)
                IDLE: begin
                    if (redirect)
                        pc_reg <= redirect_tgt;
                    state_reg <= FETCH;
                    req_reg   <= 1'b1;
                end
                FETCH: begin
                    if (redirect) begin
                        if (imem_ready) begin
                            pc_reg <= redirect_tgt;
                        end else begin
                            pending_pc_reg <= redirect_tgt;
                            state_reg      <= DROP;
                        end
                    end else if (imem_ready) begin
                        pc_reg <= pc_plus4;
                        if (!stall) begin
                            id_valid_reg    <= 1'b1;
                            id_inst_reg     <= imem_rdata;
                            id_pc_reg       <= pc_reg;
                            id_pc_plus4_reg <= pc_plus4;
                        end else begin
                            buf_inst_reg <= imem_rdata;
                            buf_pc_reg   <= pc_reg;
                            state_reg    <= HOLD;
                            req_reg      <= 1'b0;
                        end
                    end else if (!stall) begin
                        id_valid_reg    <= 1'b0;
                        id_inst_reg     <= NOP_INST;
                        id_pc_reg       <= 32'd0;
                        id_pc_plus4_reg <= 32'd0;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_reg    <= redirect_tgt;
                        state_reg <= FETCH;
                        req_reg   <= 1'b1;
                    end else if (!stall) begin
                        id_valid_reg    <= 1'b1;
                        id_inst_reg     <= buf_inst_reg;
                        id_pc_reg       <= buf_pc_reg;
                        id_pc_plus4_reg <= buf_pc_plus4;
                        state_reg       <= FETCH;
                        req_reg         <= 1'b1;
                    end
                end
                DROP: begin
                    // The old request must still complete; its data is thrown away.
                    if (redirect)
                        pending_pc_reg <= redirect_tgt;
                    if (imem_ready) begin
                        pc_reg    <= redirect ? redirect_tgt : pending_pc_reg;
                        state_reg <= FETCH;
                    end
                    if (!redirect && !stall) begin
                        id_valid_reg    <= 1'b0;
                        id_inst_reg     <= NOP_INST;
                        id_pc_reg       <= 32'd0;
                        id_pc_plus4_reg <= 32'd0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage.
// Each step drives inputs, advances one clock and checks outputs against hand-computed values.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    int checks_cnt;
    int fail_cnt;

    fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(NOP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .id_valid(id_valid),
        .id_inst(id_inst),
        .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic drive(input logic rdy, input logic [31:0] rd, input logic stl,
                         input logic rdr, input logic [31:0] rpc);
        imem_ready  = rdy;
        imem_rdata  = rd;
        stall       = stl;
        redirect    = rdr;
        redirect_pc = rpc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst_n = 1'b0;
        drive(1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'd0);
        step();
        check_val("rst_req", {31'd0, imem_req}, 32'd0);
        check_val("rst_addr", imem_addr, 32'd0);
        check_val("rst_valid", {31'd0, id_valid}, 32'd0);
        check_val("rst_inst", id_inst, NOP);
        check_val("rst_pc", id_pc, 32'd0);
        check_val("rst_pc4", id_pc_plus4, 32'd0);
        rst_n = 1'b1;

        // Reset release: IDLE, then first request at 0.
        step();
        check_val("idle_req", {31'd0, imem_req}, 32'd1);
        check_val("idle_addr", imem_addr, 32'd0);
        check_val("idle_valid", {31'd0, id_valid}, 32'd0);
        step();
        check_val("f0_inst", id_inst, 32'h0050_0093);
        check_val("f0_pc", id_pc, 32'd0);
        check_val("f0_pc4", id_pc_plus4, 32'd4);
        check_val("f0_valid", {31'd0, id_valid}, 32'd1);
        check_val("f0_addr", imem_addr, 32'd4);
        drive(1'b1, 32'h0000_1004, 1'b0, 1'b0, 32'd0);
        step();
        check_val("f4_pc", id_pc, 32'd4);
        check_val("f4_addr", imem_addr, 32'd8);

        // Stall with data ready at pc=8: buffer and hold for three cycles.
        drive(1'b1, 32'hAAAA_0008, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("hold_req", {31'd0, imem_req}, 32'd0);
            check_val("hold_idpc", id_pc, 32'd4);
            check_val("hold_inst", id_inst, 32'h0000_1004);
        end
        drive(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'd0);
        step();
        check_val("rel_pc", id_pc, 32'd8);
        check_val("rel_inst", id_inst, 32'hAAAA_0008);
        check_val("rel_pc4", id_pc_plus4, 32'd12);
        check_val("rel_addr", imem_addr, 32'd12);
        check_val("rel_req", {31'd0, imem_req}, 32'd1);
        drive(1'b1, 32'h0000_100C, 1'b0, 1'b0, 32'd0);
        step();
        check_val("f12_pc", id_pc, 32'd12);
        check_val("f12_addr", imem_addr, 32'd16);

        // Redirect while request at 16 is waiting: DROP, old data discarded.
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0103);
        step();
        check_val("drop_addr", imem_addr, 32'd16);
        check_val("drop_req", {31'd0, imem_req}, 32'd1);
        check_val("drop_valid", {31'd0, id_valid}, 32'd0);
        check_val("drop_inst", id_inst, NOP);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        step();
        check_val("drop_addr2", imem_addr, 32'd16);
        drive(1'b1, 32'hDEAD_DEAD, 1'b0, 1'b0, 32'd0);
        step();
        check_val("drop_done_addr", imem_addr, 32'h0000_0100);
        check_val("drop_done_valid", {31'd0, id_valid}, 32'd0);
        drive(1'b1, 32'h1111_0100, 1'b0, 1'b0, 32'd0);
        step();
        check_val("t100_pc", id_pc, 32'h0000_0100);
        check_val("t100_inst", id_inst, 32'h1111_0100);
        check_val("t100_addr", imem_addr, 32'h0000_0104);

        // Redirect together with stall in HOLD: buffered 0x104 never delivered.
        drive(1'b1, 32'hBBBB_0104, 1'b1, 1'b0, 32'd0);
        step();
        check_val("h2_req", {31'd0, imem_req}, 32'd0);
        drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0200);
        step();
        check_val("hr_valid", {31'd0, id_valid}, 32'd0);
        check_val("hr_inst", id_inst, NOP);
        check_val("hr_addr", imem_addr, 32'h0000_0200);
        check_val("hr_req", {31'd0, imem_req}, 32'd1);
        drive(1'b1, 32'h2222_0200, 1'b0, 1'b0, 32'd0);
        step();
        check_val("t200_pc", id_pc, 32'h0000_0200);
        check_val("t200_inst", id_inst, 32'h2222_0200);

        // Redirect with ready=1 to top of address space, then wrap.
        drive(1'b1, 32'hDEAD_0204, 1'b0, 1'b1, 32'hFFFF_FFFE);
        step();
        check_val("wr_valid", {31'd0, id_valid}, 32'd0);
        check_val("wr_addr", imem_addr, 32'hFFFF_FFFC);
        drive(1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'd0);
        step();
        check_val("wrap_pc", id_pc, 32'hFFFF_FFFC);
        check_val("wrap_pc4", id_pc_plus4, 32'd0);
        check_val("wrap_addr", imem_addr, 32'd0);

        // Memory not ready and no stall: bubble, address held.
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        step();
        check_val("bub_valid", {31'd0, id_valid}, 32'd0);
        check_val("bub_addr", imem_addr, 32'd0);
        drive(1'b1, 32'h4444_0000, 1'b0, 1'b0, 32'd0);
        step();
        check_val("t0_pc", id_pc, 32'd0);
        check_val("t0_addr", imem_addr, 32'd4);

        // Two redirects in DROP: newest target wins.
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0040);
        step();
        check_val("d2_addr", imem_addr, 32'd4);
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0080);
        step();
        check_val("d2_addr2", imem_addr, 32'd4);
        drive(1'b1, 32'hDEAD_0004, 1'b0, 1'b0, 32'd0);
        step();
        check_val("newest_addr", imem_addr, 32'h0000_0080);
        drive(1'b1, 32'h5555_0080, 1'b0, 1'b0, 32'd0);
        step();
        check_val("t80_pc", id_pc, 32'h0000_0080);
        check_val("t80_valid", {31'd0, id_valid}, 32'd1);

        // Reset asserted asynchronously while in DROP.
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0300);
        step();
        check_val("d3_addr", imem_addr, 32'h0000_0084);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("ar_req", {31'd0, imem_req}, 32'd0);
        check_val("ar_addr", imem_addr, 32'd0);
        check_val("ar_valid", {31'd0, id_valid}, 32'd0);
        check_val("ar_inst", id_inst, NOP);
        check_val("ar_pc", id_pc, 32'd0);
        step();
        rst_n = 1'b1;
        drive(1'b1, 32'h6666_0000, 1'b0, 1'b0, 32'd0);
        step();
        check_val("ar_idle_req", {31'd0, imem_req}, 32'd1);
        check_val("ar_idle_addr", imem_addr, 32'd0);
        check_val("ar_idle_valid", {31'd0, id_valid}, 32'd0);
        step();
        check_val("ar_f_pc", id_pc, 32'd0);
        check_val("ar_f_inst", id_inst, 32'h6666_0000);
        check_val("ar_f_valid", {31'd0, id_valid}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INST, 32'h0000_0013, instruction word driven on id_inst when IF/ID holds a bubble.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction-memory request valid.
REQ-006 imem_addr  output  32  fetch address, always equal to internal pc.
REQ-007 imem_ready  input  1  memory returns imem_rdata for the current request this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word, valid only with imem_ready.
REQ-009 stall  input  1  ID stage cannot accept; IF/ID register holds.
REQ-010 redirect  input  1  taken branch/jump; flush and refetch from redirect_pc.
REQ-011 redirect_pc  input  32  target address; bits [1:0] ignored, treated as 2'b00.
REQ-012 id_valid  output  1  IF/ID holds a real instruction.
REQ-013 id_inst  output  32  IF/ID instruction, feeds the immediate extender and decoder.
REQ-014 id_pc, id_pc_plus4  output  32 each  IF/ID pc and pc+4, registered.

Function
REQ-015 States IDLE, FETCH, HOLD, DROP; imem_req=1 only in FETCH and DROP.
REQ-016 IDLE: go to FETCH next cycle unconditionally, IF/ID unchanged.
REQ-017 imem_addr SHALL stay stable while imem_req=1 and imem_ready=0.
REQ-018 At most one outstanding request; a request completes only in a cycle with imem_ready=1.
REQ-019 FETCH, ready=1, stall=0, redirect=0: IF/ID <= {1, rdata, pc, pc+4}; pc <= pc+4; stay FETCH (one instruction per cycle with zero-wait memory).
REQ-020 FETCH, ready=1, stall=1, redirect=0: rdata and pc captured into a one-entry buffer; pc <= pc+4; IF/ID held; go HOLD.
REQ-021 FETCH, ready=0, redirect=0: IF/ID <= bubble {0, NOP_INST, 0, 0} if stall=0, held if stall=1.
REQ-022 HOLD: stall=0 -> IF/ID <= buffer contents (id_valid=1), go FETCH; stall=1 -> hold.
REQ-023 redirect has priority over stall in every state: IF/ID <= bubble that cycle.
REQ-024 redirect in FETCH with ready=1, or in HOLD: returned data/buffer discarded, pc <= redirect_pc, go/stay FETCH.
REQ-025 redirect in FETCH with ready=0: target saved in pending register, pc unchanged, go DROP.
REQ-026 DROP: keep request at old pc; redirect again updates pending (newest wins); on ready=1 discard rdata, pc <= pending, go FETCH; IF/ID bubble unless stall=1 (held).
REQ-027 pc arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000; id_pc_plus4 wraps identically.
REQ-028 No instruction SHALL be duplicated, skipped, or delivered after a redirect that flushed it.

Reset
REQ-029 While rst_n=0, immediately: state IDLE, pc=RESET_PC, imem_req=0, id_valid=0, id_inst=NOP_INST, id_pc=0, id_pc_plus4=0, buffer and pending cleared.
REQ-030 Reset asserted mid-request or in HOLD/DROP abandons all in-flight state; first request after release is at RESET_PC, issued in the second cycle after release.

Verification
REQ-031 Release reset, ready tied 1, rdata 32'h0050_0093 -> imem_addr 0 then 4; id_inst=32'h0050_0093, id_pc=0, id_pc_plus4=4, id_valid=1.
REQ-032 In FETCH at pc=8, ready=1 with stall=1 for 3 cycles -> HOLD, imem_req=0, IF/ID unchanged; stall drops -> id_pc=8, next imem_addr=12.
REQ-033 Request at pc=16 with ready=0, redirect to 32'h0000_0103 -> DROP, imem_addr stays 16, id_valid=0; ready=1 -> rdata discarded, next imem_addr=32'h0000_0100.
REQ-034 redirect and stall both high in HOLD -> id_valid=0, id_inst=NOP_INST, buffer discarded, fetch resumes at redirect_pc.
REQ-035 pc=32'hFFFF_FFFC, ready=1 -> id_pc_plus4=0, next imem_addr=0.
REQ-036 rst_n low during DROP -> outputs at reset values that cycle; after release first request at RESET_PC, no stale id_valid.
